// File: rtl/ascon_state_reader.sv
// ascon_state_reader
//
// Read side of the ASCON 320-bit state register. A start request snapshots the
// five 64-bit lanes and streams a contiguous lane range out as valid/ready words.
// Each lane is sent as one word when WORD_W=64. When WORD_W=32 each lane is sent
// as two words, upper half first. WORD_W must be 32 or 64.
//
// Optional build macro: ASCON_READER_KEY_XOR_EN
//   When defined, a key_i port is added. The snapshot xors the key into S3/S4
//   to form the finalization tag. Lanes 0..2 always pass through unchanged.
//
// Lane packing of state_i: S0 = state_i[63:0], S1 = [127:64], ... , S4 = [319:256].
//
// Ports
//   clock_i   in   clock
//   resetb_i  in   synchronous active-low reset
//   start_i   in   request pulse, honoured only while idle
//   first_i   in   [2:0] first lane to send (0..4)
//   count_i   in   [2:0] number of lanes to send (1..5)
//   state_i   in   [319:0] permutation state
//   key_i     in   [127:0] key (only with ASCON_READER_KEY_XOR_EN)
//   data_o    out  [WORD_W-1:0] output word
//   valid_o   out  data_o valid
//   ready_i   in   sink ready
//   last_o    out  final word of the request
//   busy_o    out  transfer in progress (SEND or DONE)
//   done_o    out  one-cycle pulse after the final handshake
//   err_o     out  one-cycle pulse on an illegal request
module ascon_state_reader #(
  parameter int WORD_W = 64
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  input  logic              start_i,
  input  logic [2:0]        first_i,
  input  logic [2:0]        count_i,
  input  logic [319:0]      state_i,
`ifdef ASCON_READER_KEY_XOR_EN
  input  logic [127:0]      key_i,
`endif
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int WPL = 64 / WORD_W;

  typedef enum logic [1:0] {IDLE, SEND, DONE} fsm_t;

  fsm_t              fsm;
  logic [4:0][63:0]  snap;
  logic [4:0][63:0]  lanes_in;
  logic [2:0]        lane_ptr;
  logic              half_ptr;
  logic [3:0]        words_left;
  logic [3:0]        req_end;
  logic              req_legal;
  logic [3:0]        req_words;
  logic [2:0]        next_lane;
  logic              next_half;

  // Lane values as they will be captured. With the key option, the tag lanes
  // are keyed at capture time so the stream never sees the raw S3/S4.
  always_comb begin
    lanes_in = state_i;
`ifdef ASCON_READER_KEY_XOR_EN
    lanes_in[3] = state_i[255:192] ^ key_i[127:64];
    lanes_in[4] = state_i[319:256] ^ key_i[63:0];
`endif
  end

  // The sum is one bit wider so that first+count cannot wrap past 5.
  assign req_end   = {1'b0, first_i} + {1'b0, count_i};
  assign req_legal = (count_i != 3'd0) && (req_end <= 4'd5);
  assign req_words = (WPL == 2) ? {count_i, 1'b0} : {1'b0, count_i};

  // Position of the word after the one currently presented. For 32-bit words
  // the pointer steps through the lower half before moving to the next lane.
  always_comb begin
    next_lane = lane_ptr;
    next_half = 1'b0;
    if (WPL == 2 && !half_ptr) next_half = 1'b1;
    else                       next_lane = lane_ptr + 3'd1;
  end

  function automatic logic [63:0] pick_lane(input logic [4:0][63:0] l,
                                            input logic [2:0] idx);
    case (idx)
      3'd0:    pick_lane = l[0];
      3'd1:    pick_lane = l[1];
      3'd2:    pick_lane = l[2];
      3'd3:    pick_lane = l[3];
      3'd4:    pick_lane = l[4];
      default: pick_lane = 64'd0;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [63:0] lane,
                                                input logic half);
    if (WPL == 1) word_of = lane[WORD_W-1:0];
    else          word_of = half ? lane[WORD_W-1:0] : lane[63 -: WORD_W];
  endfunction

  // Single FSM with registered outputs. data_o/last_o are loaded one word ahead.
  // The first word is therefore ready in the cycle after acceptance. During a
  // stall the registers simply hold their values.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm        <= IDLE;
      snap       <= '0;
      lane_ptr   <= '0;
      half_ptr   <= 1'b0;
      words_left <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start_i) begin
            if (req_legal) begin
              snap       <= lanes_in;
              lane_ptr   <= first_i;
              half_ptr   <= 1'b0;
              words_left <= req_words;
              data_o     <= word_of(pick_lane(lanes_in, first_i), 1'b0);
              last_o     <= (req_words == 4'd1);
              valid_o    <= 1'b1;
              busy_o     <= 1'b1;
              fsm        <= SEND;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        SEND: begin
          if (ready_i) begin
            if (words_left == 4'd1) begin
              valid_o <= 1'b0;
              last_o  <= 1'b0;
              data_o  <= '0;
              done_o  <= 1'b1;
              fsm     <= DONE;
            end else begin
              lane_ptr   <= next_lane;
              half_ptr   <= next_half;
              words_left <= words_left - 4'd1;
              data_o     <= word_of(pick_lane(snap, next_lane), next_half);
              last_o     <= (words_left == 4'd2);
            end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          fsm    <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_state_reader.sv
// tb_ascon_state_reader
//
// Scoreboard bench for ascon_state_reader.
// One instance is built with 64-bit words and another with 32-bit words.
// The instances share every input except their start pulses.
// Stimulus pushes hand-computed expected words into a per-instance queue.
// Monitors pop and compare each word on every handshake.
// The monitors also check that stalled words hold stable.
// They also check that done_o follows the final word.
// The key-xor case builds only when ASCON_READER_KEY_XOR_EN is defined.
module tb_ascon_state_reader;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic         clock;
  logic         resetb;
  logic         start64;
  logic         start32;
  logic [2:0]   first;
  logic [2:0]   count;
  logic [319:0] state;
  logic         ready;
`ifdef ASCON_READER_KEY_XOR_EN
  logic [127:0] key;
`endif

  logic [63:0]  data64;
  logic         valid64, last64, busy64, done64, err64;
  logic [31:0]  data32;
  logic         valid32, last32, busy32, done32, err32;

  exp_t q64[$];
  exp_t q32[$];

  int nVec  = 0;
  int nMiss = 0;
  int hs64  = 0;
  int hs32  = 0;
  int doneCnt64 = 0;

  ascon_state_reader #(.WORD_W(64)) dut64 (
    .clock_i (clock),
    .resetb_i(resetb),
    .start_i (start64),
    .first_i (first),
    .count_i (count),
    .state_i (state),
`ifdef ASCON_READER_KEY_XOR_EN
    .key_i   (key),
`endif
    .data_o  (data64),
    .valid_o (valid64),
    .ready_i (ready),
    .last_o  (last64),
    .busy_o  (busy64),
    .done_o  (done64),
    .err_o   (err64)
  );

  ascon_state_reader #(.WORD_W(32)) dut32 (
    .clock_i (clock),
    .resetb_i(resetb),
    .start_i (start32),
    .first_i (first),
    .count_i (count),
    .state_i (state),
`ifdef ASCON_READER_KEY_XOR_EN
    .key_i   (key),
`endif
    .data_o  (data32),
    .valid_o (valid32),
    .ready_i (ready),
    .last_o  (last32),
    .busy_o  (busy32),
    .done_o  (done32),
    .err_o   (err32)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] expv);
    nVec++;
    if (act !== expv) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, act, expv);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    nVec++;
    nMiss++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  function automatic logic [319:0] mkState(input logic [63:0] s0, s1, s2, s3, s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  task automatic pushExp(input bit use32, input logic [63:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    if (use32) q32.push_back(e);
    else       q64.push_back(e);
  endtask

  task automatic setReady(input logic v);
    @(posedge clock); #1;
    ready = v;
  endtask

  // Pulse start on one instance, then check the cycle after the accept edge.
  // An accepted request (or one ignored while busy) shows valid/busy with no err.
  // A rejected request shows a single err pulse with valid/busy low.
  task automatic applyStimulus(input logic [2:0] f, input logic [2:0] c,
                               input bit use32, input bit legal, input string name);
    @(posedge clock); #1;
    first = f;
    count = c;
    if (use32) start32 = 1'b1;
    else       start64 = 1'b1;
    @(posedge clock); #1;
    start64 = 1'b0;
    start32 = 1'b0;
    @(negedge clock);
    checkOutput({name, "_valid"}, use32 ? valid32 : valid64, legal);
    checkOutput({name, "_busy"},  use32 ? busy32  : busy64,  legal);
    checkOutput({name, "_err"},   use32 ? err32   : err64,   !legal);
    if (!legal) begin
      @(negedge clock);
      checkOutput({name, "_err_pulse"}, use32 ? err32 : err64, 1'b0);
    end
  endtask

  // Wait, with a bound, for done_o. Optionally toggle ready each cycle.
  // Optionally check the cycle count and the return to idle.
  task automatic waitDone(input bit use32, input int expCycles, input bit toggle,
                          input bit post, input string name);
    int cyc = 0;
    bit seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(posedge clock); #1;
      if (toggle) ready = ~ready;
      @(negedge clock);
      cyc++;
      seen = use32 ? done32 : done64;
    end
    if (!seen) reportFail({name, "_timeout"}, "done_o never rose within 200 cycles");
    else begin
      if (expCycles >= 0) checkOutput({name, "_cycles"}, 64'(cyc), 64'(expCycles));
      checkOutput({name, "_valid_in_done"}, use32 ? valid32 : valid64, 1'b0);
      if (post) begin
        @(negedge clock);
        checkOutput({name, "_idle_busy"}, use32 ? busy32 : busy64, 1'b0);
      end
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_data64"},  data64,  64'd0);
    checkOutput({name, "_valid64"}, valid64, 1'b0);
    checkOutput({name, "_last64"},  last64,  1'b0);
    checkOutput({name, "_busy64"},  busy64,  1'b0);
    checkOutput({name, "_done64"},  done64,  1'b0);
    checkOutput({name, "_err64"},   err64,   1'b0);
    checkOutput({name, "_data32"},  64'(data32), 64'd0);
    checkOutput({name, "_valid32"}, valid32, 1'b0);
    checkOutput({name, "_busy32"},  busy32,  1'b0);
  endtask

  // Monitor for the 64-bit instance.
  logic        stall64 = 1'b0;
  logic        expDone64 = 1'b0;
  logic [63:0] holdD64;
  logic        holdL64;
  always @(negedge clock) begin
    exp_t e;
    if (!resetb) begin
      stall64   = 1'b0;
      expDone64 = 1'b0;
    end else begin
      if (done64) doneCnt64++;
      if (done64 || expDone64) checkOutput("done64", done64, expDone64);
      expDone64 = 1'b0;
      if (stall64) begin
        checkOutput("hold_data64", data64, holdD64);
        checkOutput("hold_last64", last64, holdL64);
      end
      stall64 = valid64 && !ready;
      holdD64 = data64;
      holdL64 = last64;
      if (valid64 && ready) begin
        hs64++;
        if (q64.size() == 0) reportFail("word64", "word presented with empty scoreboard");
        else begin
          e = q64.pop_front();
          checkOutput("data64", data64, e.data);
          checkOutput("last64", last64, e.last);
          expDone64 = e.last;
        end
      end
    end
  end

  // Monitor for the 32-bit instance.
  logic        stall32 = 1'b0;
  logic        expDone32 = 1'b0;
  logic [31:0] holdD32;
  logic        holdL32;
  always @(negedge clock) begin
    exp_t e;
    if (!resetb) begin
      stall32   = 1'b0;
      expDone32 = 1'b0;
    end else begin
      if (done32 || expDone32) checkOutput("done32", done32, expDone32);
      expDone32 = 1'b0;
      if (stall32) begin
        checkOutput("hold_data32", 64'(data32), 64'(holdD32));
        checkOutput("hold_last32", last32, holdL32);
      end
      stall32 = valid32 && !ready;
      holdD32 = data32;
      holdL32 = last32;
      if (valid32 && ready) begin
        hs32++;
        if (q32.size() == 0) reportFail("word32", "word presented with empty scoreboard");
        else begin
          e = q32.pop_front();
          checkOutput("data32", 64'(data32), e.data);
          checkOutput("last32", last32, e.last);
          expDone32 = e.last;
        end
      end
    end
  end

  initial begin
    int hsBase;
    int doneBase;
    resetb  = 1'b0;
    start64 = 1'b0;
    start32 = 1'b0;
    first   = '0;
    count   = '0;
    state   = '0;
    ready   = 1'b0;
`ifdef ASCON_READER_KEY_XOR_EN
    key     = '0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkReset("reset_state");
    @(posedge clock); #1;
    resetb = 1'b1;

    // Full state, 64-bit words, sink always ready
    state = mkState(64'h0000000000000000, 64'h1111111111111111, 64'h2222222222222222,
                    64'h3333333333333333, 64'h4444444444444444);
    setReady(1'b1);
    pushExp(0, 64'h0000000000000000, 0);
    pushExp(0, 64'h1111111111111111, 0);
    pushExp(0, 64'h2222222222222222, 0);
    pushExp(0, 64'h3333333333333333, 0);
    pushExp(0, 64'h4444444444444444, 1);
    applyStimulus(3'd0, 3'd5, 0, 1, "full");
    waitDone(0, 5, 0, 0, "full");
    // back-to-back: accepted in the idle cycle right after DONE
    pushExp(0, 64'h1111111111111111, 1);
    applyStimulus(3'd1, 3'd1, 0, 1, "b2b");
    waitDone(0, 1, 0, 1, "b2b");
    checkOutput("full_queue_drained", 64'(q64.size()), 64'd0);

    // Backpressure with ready toggling 1,0,1,...; state changes after accept
    hsBase = hs64;
    pushExp(0, 64'h3333333333333333, 0);
    pushExp(0, 64'h4444444444444444, 1);
    applyStimulus(3'd3, 3'd2, 0, 1, "bp");
    state = mkState(64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5,
                    64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5);
    waitDone(0, -1, 1, 1, "bp");
    checkOutput("bp_handshakes", 64'(hs64 - hsBase), 64'd2);
    setReady(1'b1);

    // 32-bit words, single lane, upper half first
    state = mkState(64'd0, 64'd0, 64'd0, 64'd0, 64'hDEADBEEF01234567);
    pushExp(1, 64'h00000000DEADBEEF, 0);
    pushExp(1, 64'h0000000001234567, 1);
    applyStimulus(3'd4, 3'd1, 1, 1, "w32a");
    waitDone(1, 2, 0, 1, "w32a");
    state = mkState(64'hAAAA0000BBBB1111, 64'hCCCC2222DDDD3333, 64'd0, 64'd0, 64'd0);
    hsBase = hs32;
    pushExp(1, 64'h00000000AAAA0000, 0);
    pushExp(1, 64'h00000000BBBB1111, 0);
    pushExp(1, 64'h00000000CCCC2222, 0);
    pushExp(1, 64'h00000000DDDD3333, 1);
    applyStimulus(3'd0, 3'd2, 1, 1, "w32b");
    waitDone(1, 4, 0, 1, "w32b");
    checkOutput("w32_handshakes", 64'(hs32 - hsBase), 64'd4);

    // Illegal requests: range overflow and zero count
    applyStimulus(3'd4, 3'd2, 0, 0, "ill_range");
    applyStimulus(3'd0, 3'd0, 0, 0, "ill_zero");
    applyStimulus(3'd2, 3'd4, 1, 0, "ill_range32");

    // start while busy is ignored: no err, no second transfer
    state = mkState(64'h0000000000000000, 64'h1111111111111111, 64'h2222222222222222,
                    64'h3333333333333333, 64'h4444444444444444);
    setReady(1'b0);
    hsBase   = hs64;
    doneBase = doneCnt64;
    pushExp(0, 64'h2222222222222222, 1);
    applyStimulus(3'd2, 3'd1, 0, 1, "busy_req");
    applyStimulus(3'd0, 3'd5, 0, 1, "busy_ignored");
    setReady(1'b1);
    waitDone(0, -1, 0, 1, "busy_req");
    repeat (3) @(negedge clock);
    checkOutput("busy_no_queue_valid", valid64, 1'b0);
    checkOutput("busy_handshakes", 64'(hs64 - hsBase), 64'd1);
    checkOutput("busy_done_count", 64'(doneCnt64 - doneBase), 64'd1);

    // Reset held for 2 cycles in the middle of a stalled transfer
    setReady(1'b0);
    doneBase = doneCnt64;
    applyStimulus(3'd0, 3'd5, 0, 1, "mid_rst");
    @(posedge clock); #1;
    resetb = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkReset("mid_rst_hold");
    @(posedge clock); #1;
    resetb = 1'b1;
    setReady(1'b1);
    repeat (3) begin
      @(negedge clock);
      checkOutput("mid_rst_valid", valid64, 1'b0);
    end
    checkOutput("mid_rst_done_count", 64'(doneCnt64 - doneBase), 64'd0);
    pushExp(0, 64'h0000000000000000, 1);
    applyStimulus(3'd0, 3'd1, 0, 1, "after_rst");
    waitDone(0, 1, 0, 1, "after_rst");

`ifdef ASCON_READER_KEY_XOR_EN
    // Keyed tag lanes
    state = mkState(64'd0, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    key   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    pushExp(0, 64'hFEDCBA9876543210, 0);
    pushExp(0, 64'h0123456789ABCDEF, 1);
    applyStimulus(3'd3, 3'd2, 0, 1, "key");
    waitDone(0, 2, 0, 1, "key");
    key = '0;
`endif

    repeat (2) @(negedge clock);
    checkOutput("q64_drained", 64'(q64.size()), 64'd0);
    checkOutput("q32_drained", 64'(q32.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
